noc_out_arbiter: RTL

NOC_OUT_ARBITER -- requirements
Module: noc_out_arbiter

---
 rtl/noc_out_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/noc_out_arbiter.sv
// noc_out_arbiter: round-robin output arbiter with packet locking, a registered
// output slot and a forced lock release when the owner goes idle too long.
module noc_out_arbiter #(
   parameter int DATA_WIDTH   = 216,
   parameter int NUM_PORTS    = 5,
   parameter int LAST_BIT     = DATA_WIDTH-1,
   parameter int LOCK_TIMEOUT = 255
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_PORTS-1:0]            req_valid,
   output logic [NUM_PORTS-1:0]            req_clear,
   output logic [DATA_WIDTH-1:0]           out_data,
   output logic                            out_valid,
   input  logic                            out_busy,
   output logic [NUM_PORTS-1:0]            owner,
   output logic                            locked,
   output logic                            lock_timeout
);
   localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT+1) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_TIMEOUT);

   logic [IW-1:0]         ptr_q, ptr_d, own_q, own_d, win_idx, cand;
   logic                  locked_q, locked_d, out_valid_q, out_valid_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d, win_data;
   logic [NUM_PORTS-1:0]  eligible;
   logic                  found, slot_free, capture, timeout;

   assign owner        = locked_q ? (NUM_PORTS'(1) << own_q) : '0;
   assign locked       = locked_q;
   assign out_data     = out_data_q;
   assign out_valid    = out_valid_q;
   assign lock_timeout = timeout;

   always_comb begin
      eligible = locked_q ? (req_valid & owner) : req_valid;
      found    = 1'b0;
      win_idx  = '0;
      cand     = '0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         cand = IW'((int'(ptr_q) + i) % NUM_PORTS);
         if (!found && eligible[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
      end
      timeout   = (LOCK_TIMEOUT > 0) && locked_q && (cnt_q == CNT_MAX);
      slot_free = !out_valid_q || !out_busy;
      // reset gates the handshake so requesters never advance while held in reset
      capture   = rst && slot_free && found && !timeout;
      win_data  = req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
      req_clear = capture ? (NUM_PORTS'(1) << win_idx) : '0;
      out_data_d  = capture ? win_data : out_data_q;
      out_valid_d = capture || (out_valid_q && out_busy);
      cnt_d = (LOCK_TIMEOUT > 0 && locked_q && !req_valid[own_q] && !timeout) ? cnt_q + 1'b1 : '0;
      locked_d = locked_q;
      own_d    = own_q;
      ptr_d    = ptr_q;
      if (timeout) begin
         locked_d = 1'b0;
         ptr_d    = own_q;
      end else if (capture && win_data[LAST_BIT]) begin
         locked_d = 1'b0;
         ptr_d    = win_idx;
      end else if (capture) begin
         locked_d = 1'b1;
         own_d    = win_idx;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q       <= IW'(NUM_PORTS-1);
         own_q       <= '0;
         locked_q    <= 1'b0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         own_q       <= own_d;
         locked_q    <= locked_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end
endmodule
